ifid_elastic_reg: RTL and testbench

IFID_ELASTIC_REG -- requirements
Module: ifid_elastic_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/ifid_elastic_reg_stall_cnt.sv | 30 +++
 rtl/ifid_elastic_reg.sv | 109 ++++++++++
 tb/tb_ifid_elastic_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: elastic-stage occupancy encoding and the default bubble encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  localparam logic [31:0] BubbleInstDefault = 32'hF0F0F0F0;

  function automatic logic occ_has_head(occ_e occ);
    return occ != OccEmpty;
  endfunction

endpackage

// File: rtl/ifid_elastic_reg_stall_cnt.sv
// Saturating up-counter of cycles in which the stage held a valid head that decode refused.
module ifid_elastic_reg_stall_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ifid_elastic_reg.sv
// IF/ID pipeline register as a 2-entry elastic buffer (head + skid) with a registered in_ready.
module ifid_elastic_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          PC_SIZE     = 32,
  parameter int unsigned          INST_SIZE   = 32,
  parameter logic [INST_SIZE-1:0] BUBBLE_INST = INST_SIZE'(BubbleInstDefault)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_SIZE-1:0]   IFID_PCplus4_in,
  input  logic [INST_SIZE-1:0] inst,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PC_SIZE-1:0]   IFID_PCplus4_out,
  output logic [INST_SIZE-1:0] inst_decode,
  output logic                 IFID_bubble_out,
  output logic [15:0]          stall_cnt
);

  occ_e                 occ_d, occ_q;
  logic                 in_ready_d, in_ready_q;
  logic [PC_SIZE-1:0]   head_pc_d, head_pc_q, skid_pc_d, skid_pc_q;
  logic [INST_SIZE-1:0] head_inst_d, head_inst_q, skid_inst_d, skid_inst_q;
  logic                 accept, consume;

  assign out_valid = occ_has_head(occ_q);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    unique case (occ_q)
      OccEmpty: begin
        if (accept) begin
          occ_d       = OccOne;
          head_pc_d   = IFID_PCplus4_in;
          head_inst_d = inst;
        end
      end
      OccOne: begin
        if (accept && consume) begin
          head_pc_d   = IFID_PCplus4_in;
          head_inst_d = inst;
        end else if (accept) begin
          occ_d       = OccFull;
          skid_pc_d   = IFID_PCplus4_in;
          skid_inst_d = inst;
        end else if (consume) begin
          occ_d = OccEmpty;
        end
      end
      OccFull: begin
        // in_ready is low here, so only a consume can move the skid entry forward.
        if (consume) begin
          occ_d       = OccOne;
          head_pc_d   = skid_pc_q;
          head_inst_d = skid_inst_q;
        end
      end
      default: occ_d = OccEmpty;
    endcase
    if (flush) begin
      occ_d = OccEmpty;
    end
    // Ready is a pure function of the next occupancy: no path from out_ready to in_ready.
    in_ready_d = (occ_d != OccFull);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= OccEmpty;
      in_ready_q  <= 1'b0;
      head_pc_q   <= '0;
      head_inst_q <= BUBBLE_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= BUBBLE_INST;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign IFID_bubble_out  = ~out_valid;
  assign inst_decode      = out_valid ? head_inst_q : BUBBLE_INST;
  assign IFID_PCplus4_out = out_valid ? head_pc_q : '0;

  ifid_elastic_reg_stall_cnt #(
    .Width (16)
  ) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .stall_i (out_valid & ~out_ready),
    .cnt_o   (stall_cnt)
  );

endmodule

// File: tb/tb_ifid_elastic_reg.sv
// Scoreboard bench for ifid_elastic_reg: accepted entries queued, compared as the head is observed.
module tb_ifid_elastic_reg;

  localparam logic [31:0] Bubble = 32'hF0F0F0F0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_decode;
  logic        bubble_out;
  logic [15:0] stall_cnt;

  entry_t      sb_q[$];
  logic        m_rdy = 1'b0;
  logic [15:0] m_stall = '0;
  logic        chk_en = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ifid_elastic_reg dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .IFID_PCplus4_in  (pc_in),
    .inst             (inst_in),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .IFID_PCplus4_out (pc_out),
    .inst_decode      (inst_decode),
    .IFID_bubble_out  (bubble_out),
    .stall_cnt        (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model state for the current cycle.
  task automatic check_outputs();
    logic        exp_v;
    logic [31:0] exp_inst, exp_pc;
    exp_v    = (sb_q.size() != 0);
    exp_inst = exp_v ? sb_q[0].inst : Bubble;
    exp_pc   = exp_v ? sb_q[0].pc : 32'd0;
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    check_eq("bubble", {63'd0, bubble_out}, {63'd0, ~exp_v});
    check_eq("inst_decode", {32'd0, inst_decode}, {32'd0, exp_inst});
    check_eq("pc_out", {32'd0, pc_out}, {32'd0, exp_pc});
    check_eq("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
  endtask

  task automatic step(input logic iv, input logic [31:0] ipc, input logic [31:0] iinst,
                      input logic ordy, input logic fl);
    logic acc, con;
    @(negedge clk);
    in_valid  = iv;
    pc_in     = ipc;
    inst_in   = iinst;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (chk_en) check_outputs();
    acc = iv & m_rdy;
    con = (sb_q.size() != 0) & ordy;
    if ((sb_q.size() != 0) && !ordy && (m_stall != 16'hFFFF)) m_stall++;
    @(posedge clk);
    if (con) void'(sb_q.pop_front());
    if (acc) sb_q.push_back('{pc: ipc, inst: iinst});
    if (fl) sb_q.delete();
    m_rdy = (sb_q.size() < 2);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    // Reset held for three cycles
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs();
    end
    reset = 1'b1;
    #1;
    check_eq("rdy_after_release", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("rdy_first_edge", {63'd0, in_ready}, 64'd1);
    m_rdy = 1'b1;

    // Streaming with decode always ready
    step(1'b1, 32'd4, 32'h11, 1'b1, 1'b0);
    step(1'b1, 32'd8, 32'h22, 1'b1, 1'b0);
    step(1'b1, 32'd12, 32'h33, 1'b1, 1'b0);
    idle(2, 1'b1);
    check_eq("stream_stall", {48'd0, stall_cnt}, 64'd0);

    // Backpressure: third instruction waits upstream until decode frees space
    step(1'b1, 32'd4, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'd8, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'd12, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'd12, 32'h33, 1'b0, 1'b0);
    check_eq("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    step(1'b1, 32'd12, 32'h33, 1'b1, 1'b0);
    step(1'b1, 32'd12, 32'h33, 1'b1, 1'b0);
    idle(3, 1'b1);
    check_eq("bp_stall_cnt", {48'd0, stall_cnt}, 64'd3);

    // Flush while full, with a new instruction offered in the same cycle
    step(1'b1, 32'd16, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'd20, 32'h66, 1'b0, 1'b0);
    step(1'b1, 32'd24, 32'h44, 1'b0, 1'b1);
    #1;
    check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_inst", {32'd0, inst_decode}, {32'd0, Bubble});
    idle(3, 1'b1);

    // Continuous accept + consume while holding one entry
    step(1'b1, 32'd100, 32'hA0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 32'd100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
    end
    idle(2, 1'b1);

    // Asynchronous reset mid-operation drops held entries
    step(1'b1, 32'd200, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 32'd204, 32'hB2, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_rdy   = 1'b0;
    m_stall = '0;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    m_rdy = 1'b1;
    idle(2, 1'b1);

    // Saturation of the stall counter
    step(1'b1, 32'd300, 32'hC1, 1'b0, 1'b0);
    chk_en = 1'b0;
    idle(70000, 1'b0);
    chk_en = 1'b1;
    #1;
    check_eq("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    check_eq("sat_head", {32'd0, inst_decode}, 64'hC1);
    idle(1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(2, 1'b1);
    check_eq("sat_after_flush", {48'd0, stall_cnt}, 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
